// File: rtl/cpu_common_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_common_pkg : shared CPU types and write-back requester indices. Rev 1.0
// ----------------------------------------------------------------------------
package cpu_common_pkg;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    regaddr_t rd;
    word_t    data;
  } wb_req_t;

  localparam int WB_N_REQ   = 4;
  localparam int WB_REQ_ALU = 0;
  localparam int WB_REQ_LSU = 1;
  localparam int WB_REQ_CSR = 2;
  localparam int WB_REQ_MUL = 3;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : generic N-way round-robin picker (requests + pointer -> grant). Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  localparam logic [PW:0] c_n = (PW+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [PW-1:0]  w_off;
  logic [PW:0]    w_sum;

  // Rotate the request vector so the pointer position lands on bit 0.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign o_any = |i_req;

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_dbl[i]) w_off = PW'(i);
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= c_n) w_sum = w_sum - c_n;
  end

  assign o_idx = w_sum[PW-1:0];

  always_comb begin
    o_gnt = '0;
    for (int j = 0; j < N; j++) begin
      o_gnt[j] = o_any && (o_idx == PW'(j));
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_arbiter : round-robin share of the register-file write port. Rev 1.0
// ----------------------------------------------------------------------------
module wb_arbiter
  import cpu_common_pkg::*;
#(
  parameter int N_REQ   = WB_N_REQ,
  parameter int RR_INIT = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  regaddr_t [N_REQ-1:0]   req_rd_i,
  input  word_t    [N_REQ-1:0]   req_data_i,
  input  logic     [N_REQ-1:0]   req_valid_i,
  output logic     [N_REQ-1:0]   req_ready_o,
  output regaddr_t               rf_wr_addr_o,
  output word_t                  rf_wr_data_o,
  output logic                   rf_wr_en_o,
  output logic     [N_REQ-1:0]   grant_o,
  output logic     [N_REQ-1:0]   pending_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    r_ptr;
  logic             r_wen;
  regaddr_t         r_addr;
  word_t            r_data;
  logic [N_REQ-1:0] r_grant;

  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic             w_xfer;
  wb_req_t          w_win;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign req_ready_o = w_gnt & {N_REQ{rst_ni}};
  assign pending_o   = req_valid_i & ~req_ready_o;
  assign w_xfer      = w_any & rst_ni;
  assign w_win.rd    = req_rd_i[w_idx];
  assign w_win.data  = req_data_i[w_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr   <= PW'(RR_INIT);
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_grant <= '0;
    end else begin
      r_wen   <= 1'b0;
      r_grant <= '0;
      if (w_xfer) begin
        r_ptr   <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + PW'(1);
        r_grant <= w_gnt;
        // Writes to x0 are consumed but never reach the register file.
        if (w_win.rd != '0) begin
          r_wen  <= 1'b1;
          r_addr <= w_win.rd;
          r_data <= w_win.data;
        end
      end
    end
  end

  assign rf_wr_en_o   = r_wen;
  assign rf_wr_addr_o = r_addr;
  assign rf_wr_data_o = r_data;
  assign grant_o      = r_grant;

  a_ready_onehot0 : assert property (@(posedge clk_i) $onehot0(req_ready_o));

  generate
    for (genvar k = 0; k < N_REQ; k++) begin : g_req_chk
      a_ready_needs_valid : assert property (@(posedge clk_i)
        req_ready_o[k] |-> req_valid_i[k]);
      a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i[k] && !req_ready_o[k]) |=> req_valid_i[k]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wb_arbiter : directed vector table plus randomized model check. Rev 1.0
// ----------------------------------------------------------------------------
module tb_wb_arbiter;
  import cpu_common_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic             rstn;
    logic [N-1:0]     valid;
    logic [N-1:0][4:0]  rd;
    logic [N-1:0][31:0] data;
    logic [N-1:0]     ready;
    logic             wen;
    logic [4:0]       addr;
    logic [31:0]      wdata;
    logic [N-1:0]     grant;
  } vec_t;

  localparam logic [N-1:0][4:0]  C_RD = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [N-1:0][31:0] C_DT = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  regaddr_t [N-1:0] req_rd = '0;
  word_t    [N-1:0] req_data = '0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  regaddr_t         rf_wr_addr;
  word_t            rf_wr_data;
  logic             rf_wr_en;
  logic [N-1:0]     grant;
  logic [N-1:0]     pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.N_REQ(N), .RR_INIT(0)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_rd_i     (req_rd),
    .req_data_i   (req_data),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .rf_wr_addr_o (rf_wr_addr),
    .rf_wr_data_o (rf_wr_data),
    .rf_wr_en_o   (rf_wr_en),
    .grant_o      (grant),
    .pending_o    (pending)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  vec_t vecs[$];

  // Reference model state for the random phase
  int          mptr;
  logic        mwen;
  logic [4:0]  maddr;
  logic [31:0] mdata;
  logic [N-1:0] mgnt;
  logic        v [N];
  logic [4:0]  r [N];
  logic [31:0] d [N];
  int          waits [N];

  initial begin
    // rst, valid, rd, data, exp ready, then registered wen/addr/data/grant after the edge
    vecs.push_back('{1'b0, 4'b0000, '0, '0, 4'b0000, 1'b0, 5'd0, 32'h0, 4'b0000});
    vecs.push_back('{1'b0, 4'b0000, '0, '0, 4'b0000, 1'b0, 5'd0, 32'h0, 4'b0000});
    vecs.push_back('{1'b1, 4'b0000, '0, '0, 4'b0000, 1'b0, 5'd0, 32'h0, 4'b0000});
    vecs.push_back('{1'b1, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd0}, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
                     4'b0010, 1'b1, 5'd5, 32'hDEADBEEF, 4'b0010});
    vecs.push_back('{1'b1, 4'b0000, '0, '0, 4'b0000, 1'b0, 5'd5, 32'hDEADBEEF, 4'b0000});
    vecs.push_back('{1'b1, 4'b0001, '0, {32'h0, 32'h0, 32'h0, 32'h1234},
                     4'b0001, 1'b0, 5'd5, 32'hDEADBEEF, 4'b0001});
    vecs.push_back('{1'b1, 4'b1001, C_RD, C_DT, 4'b1000, 1'b1, 5'd4, 32'hA000_0003, 4'b1000});
    vecs.push_back('{1'b1, 4'b1001, C_RD, C_DT, 4'b0001, 1'b1, 5'd1, 32'hA000_0000, 4'b0001});
    vecs.push_back('{1'b1, 4'b1001, C_RD, C_DT, 4'b1000, 1'b1, 5'd4, 32'hA000_0003, 4'b1000});
    vecs.push_back('{1'b1, 4'b1111, C_RD, C_DT, 4'b0001, 1'b1, 5'd1, 32'hA000_0000, 4'b0001});
    vecs.push_back('{1'b1, 4'b1111, C_RD, C_DT, 4'b0010, 1'b1, 5'd2, 32'hA000_0001, 4'b0010});
    vecs.push_back('{1'b1, 4'b1111, C_RD, C_DT, 4'b0100, 1'b1, 5'd3, 32'hA000_0002, 4'b0100});
    vecs.push_back('{1'b1, 4'b1111, C_RD, C_DT, 4'b1000, 1'b1, 5'd4, 32'hA000_0003, 4'b1000});
    vecs.push_back('{1'b1, 4'b1111, C_RD, C_DT, 4'b0001, 1'b1, 5'd1, 32'hA000_0000, 4'b0001});
    vecs.push_back('{1'b1, 4'b1111, C_RD, C_DT, 4'b0010, 1'b1, 5'd2, 32'hA000_0001, 4'b0010});
    vecs.push_back('{1'b1, 4'b1111, C_RD, C_DT, 4'b0100, 1'b1, 5'd3, 32'hA000_0002, 4'b0100});
    vecs.push_back('{1'b0, 4'b1111, C_RD, C_DT, 4'b0000, 1'b0, 5'd0, 32'h0, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, C_RD, C_DT, 4'b0001, 1'b1, 5'd1, 32'hA000_0000, 4'b0001});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n     = vecs[i].rstn;
      req_valid = vecs[i].valid;
      req_rd    = vecs[i].rd;
      req_data  = vecs[i].data;
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].ready));
      chk($sformatf("vec%0d_pending", i), 64'(pending), 64'(vecs[i].valid & ~vecs[i].ready));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wen", i), 64'(rf_wr_en), 64'(vecs[i].wen));
      chk($sformatf("vec%0d_addr", i), 64'(rf_wr_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_data", i), 64'(rf_wr_data), 64'(vecs[i].wdata));
      chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].grant));
    end

    // Clean reset before the randomized phase
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk);
    mptr = 0; mwen = 1'b0; maddr = '0; mdata = '0; mgnt = '0;
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b0; r[k] = '0; d[k] = '0; waits[k] = 0;
    end

    for (int c = 0; c < 500; c++) begin
      logic       rstv;
      logic       found;
      int         win;
      logic [N-1:0] exp_ready;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!v[k] && $urandom_range(0, 2) != 0) begin
          v[k] = 1'b1;
          r[k] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          d[k] = $urandom;
        end
        req_valid[k] = v[k];
        req_rd[k]    = r[k];
        req_data[k]  = d[k];
      end
      rstv  = ($urandom_range(0, 49) != 0);
      rst_n = rstv;
      found = 1'b0;
      win   = 0;
      for (int j = 0; j < N; j++) begin
        if (!found && v[(mptr + j) % N]) begin
          found = 1'b1;
          win   = (mptr + j) % N;
        end
      end
      exp_ready = (rstv && found) ? N'(1 << win) : '0;
      #1;
      chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
      chk("rnd_pending", 64'(pending), 64'(req_valid & ~exp_ready));
      for (int k = 0; k < N; k++) begin
        if (!rstv) waits[k] = 0;
        else if (v[k]) begin
          if (req_ready[k]) begin
            chk("rnd_fair_wait", 64'(waits[k] < N), 64'd1);
            waits[k] = 0;
          end else begin
            waits[k]++;
          end
        end
      end
      @(posedge clk);
      if (!rstv) begin
        mptr = 0; mwen = 1'b0; maddr = '0; mdata = '0; mgnt = '0;
      end else if (found) begin
        mptr = (win + 1) % N;
        mgnt = N'(1 << win);
        mwen = (r[win] != 5'd0);
        if (r[win] != 5'd0) begin
          maddr = r[win];
          mdata = d[win];
        end
        v[win] = 1'b0;
      end else begin
        mwen = 1'b0;
        mgnt = '0;
      end
      #1;
      chk("rnd_wen", 64'(rf_wr_en), 64'(mwen));
      chk("rnd_addr", 64'(rf_wr_addr), 64'(maddr));
      chk("rnd_data", 64'(rf_wr_data), 64'(mdata));
      chk("rnd_grant", 64'(grant), 64'(mgnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
